// File: rtl/usb_fifo_reg_reader_pkg.sv
// Shared definitions for the capture-FIFO register reader:
// register addresses, status/control bit positions and prefetch FSM encoding.
package usb_fifo_reg_reader_pkg;

    localparam logic [7:0] FIFO_ADDR_DEF = 8'h20;
    localparam logic [7:0] STAT_ADDR_DEF = 8'h21;

    // Status byte 0 bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_UNDERFLOW = 2;

    // Status byte 3 bit position
    localparam int STAT_HOLD_VALID = 0;

    // Control byte 0 bit positions
    localparam int CTRL_CLR_UNDERFLOW = 0;
    localparam int CTRL_FLUSH         = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/usb_fifo_reg_reader.sv
// Byte-serial register view of a 32-bit capture FIFO with a one-word
// prefetch holding register plus a status/control register.
module usb_fifo_reg_reader
    import usb_fifo_reg_reader_pkg::*;
#(
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [7:0] pFIFO_ADDR    = FIFO_ADDR_DEF,
    parameter logic [7:0] pSTAT_ADDR    = STAT_ADDR_DEF,
    parameter int         pCOUNT_WIDTH  = 16
) (
    input  logic                     cwusb_clk,
    input  logic                     reset,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datao,
    output logic [7:0]               reg_datai,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic                     reg_addrvalid,
    output logic                     fifo_rd_en,
    input  logic [31:0]              fifo_dout,
    input  logic                     fifo_empty,
    input  logic                     fifo_overflow,
    input  logic [pCOUNT_WIDTH-1:0]  fifo_count,
    output logic                     fifo_flush
);

    fetch_state_t r_state;
    logic [31:0]  r_hold_word;
    logic         r_hold_valid;
    logic         r_underflow;
    logic         r_read_d;
    logic [7:0]   r_datai;
    logic         r_rd_en;
    logic         r_flush;

    logic         w_fifo_sel;
    logic         w_stat_sel;
    logic [1:0]   w_byte_idx;
    logic         w_consume;
    logic         w_ctrl_wr;
    logic         w_flush_wr;
    logic         w_clr_unf;
    logic         w_set_unf;
    logic [15:0]  w_count16;
    logic [7:0]   w_stat_byte;
    logic [7:0]   w_rd_byte;

    if (pCOUNT_WIDTH >= 16) begin : g_cnt_trunc
        assign w_count16 = fifo_count[15:0];
    end else begin : g_cnt_ext
        assign w_count16 = {{(16-pCOUNT_WIDTH){1'b0}}, fifo_count};
    end

    assign w_fifo_sel = reg_addrvalid && (reg_address == pFIFO_ADDR);
    assign w_stat_sel = reg_addrvalid && (reg_address == pSTAT_ADDR);
    assign w_byte_idx = reg_bytecnt[1:0];

    // Front end bumps bytecnt on this same edge, so the old index is seen here
    assign w_consume = r_read_d && !reg_read && w_fifo_sel
                     && (w_byte_idx == 2'd3);

    assign w_ctrl_wr  = reg_write && w_stat_sel && (reg_bytecnt == '0);
    assign w_flush_wr = w_ctrl_wr && reg_datao[CTRL_FLUSH];
    assign w_clr_unf  = w_ctrl_wr && reg_datao[CTRL_CLR_UNDERFLOW];
    assign w_set_unf  = reg_read && w_fifo_sel && !r_hold_valid;

    always_comb begin
        w_stat_byte = 8'h00;
        case (w_byte_idx)
            2'd0: begin
                w_stat_byte[STAT_EMPTY]     = fifo_empty;
                w_stat_byte[STAT_OVERFLOW]  = fifo_overflow;
                w_stat_byte[STAT_UNDERFLOW] = r_underflow;
            end
            2'd1: w_stat_byte = w_count16[7:0];
            2'd2: w_stat_byte = w_count16[15:8];
            default: w_stat_byte[STAT_HOLD_VALID] = r_hold_valid;
        endcase
    end

    always_comb begin
        w_rd_byte = 8'h00;
        unique case (1'b1)
            w_fifo_sel: begin
                if (r_hold_valid) begin
                    w_rd_byte = word_byte(r_hold_word, w_byte_idx);
                end
            end
            w_stat_sel: w_rd_byte = w_stat_byte;
            default:    w_rd_byte = 8'h00;
        endcase
    end

    // Prefetch FSM; a flush request overrides any fetch in flight
    always_ff @(posedge cwusb_clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hold_word  <= 32'h0;
            r_hold_valid <= 1'b0;
            r_rd_en      <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_flush <= 1'b0;
            if (w_flush_wr) begin
                r_state      <= IDLE;
                r_hold_valid <= 1'b0;
                r_flush      <= 1'b1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!r_hold_valid && !fifo_empty && !r_flush) begin
                            r_state <= FETCH;
                            r_rd_en <= 1'b1;
                        end
                    end
                    FETCH: r_state <= LATCH;
                    LATCH: begin
                        r_hold_word  <= fifo_dout;
                        r_hold_valid <= 1'b1;
                        r_state      <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
                if (w_consume && (r_state != LATCH)) begin
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset) begin
            r_read_d <= 1'b0;
        end else begin
            r_read_d <= reg_read;
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (w_set_unf) begin
            r_underflow <= 1'b1;
        end else if (w_clr_unf) begin
            r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset) begin
            r_datai <= 8'h00;
        end else if (reg_read) begin
            r_datai <= w_rd_byte;
        end
    end

    assign reg_datai  = r_datai;
    assign fifo_rd_en = r_rd_en;
    assign fifo_flush = r_flush;

endmodule
